// File: rtl/sram_array.sv
// Line-organised SRAM with full-line or single-word writes and a registered, write-first read port.
// readValid reports whether readData reflects the current contents of the line at readAddr.
module sram_array #(
   parameter int WIDTH         = 64,
   parameter int LOGDEPTH      = 9,
   parameter int LOGLINEOFFSET = 3
) (
   input  logic [WIDTH-1:0]         writeData,
   output logic [WIDTH-1:0]         readData,
   output logic                     readValid,
   input  logic [LOGDEPTH-1:0]      writeAddr,
   input  logic [LOGDEPTH-1:0]      readAddr,
   input  logic [LOGLINEOFFSET:0]   writeOffset,
   input  logic                     writeEnable,
   input  logic                     clk,
   input  logic                     rst_n
);

   localparam int DEPTH = 1 << LOGDEPTH;
   localparam int WORDS = 1 << LOGLINEOFFSET;
   localparam int W     = WIDTH >> LOGLINEOFFSET;

   // Contents start at zero and are deliberately untouched by reset.
   logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

   logic [WORDS-1:0]    wordSel;
   logic [WIDTH-1:0]    mergedLine;
   logic [LOGDEPTH-1:0] addrReg;
   logic                started;
   logic                doWrite;

   generate
      if (LOGLINEOFFSET == 0) begin : g_single
         // A line is a single word, so both write modes replace the whole line.
         assign wordSel = '1;
      end else begin : g_multi
         always_comb begin
            wordSel = '0;
            for (int k = 0; k < WORDS; k++) begin
               wordSel[k] = writeOffset[LOGLINEOFFSET] ||
                            (writeOffset[LOGLINEOFFSET-1:0] == LOGLINEOFFSET'(k));
            end
         end
      end
   endgenerate

   // Post-write image of line writeAddr; feeds both the array and the write-first bypass.
   always_comb begin
      mergedLine = mem[writeAddr];
      for (int k = 0; k < WORDS; k++) begin
         if (wordSel[k]) mergedLine[k*W +: W] = writeData[k*W +: W];
      end
   end

   assign doWrite = writeEnable && rst_n;

   always_ff @(posedge clk) begin
      if (doWrite) mem[writeAddr] <= mergedLine;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         readData <= '0;
         addrReg  <= '0;
         started  <= 1'b0;
      end else begin
         readData <= (writeEnable && (writeAddr == readAddr)) ? mergedLine : mem[readAddr];
         addrReg  <= readAddr;
         started  <= 1'b1;
      end
   end

   // Stale if the address moved since the last capture or a write to that line is about to land.
   assign readValid = started && (addrReg == readAddr) &&
                      !(writeEnable && (writeAddr == addrReg));

endmodule

// File: tb/tb_sram_array.sv
// Directed bench for sram_array at default parameters (64-bit lines, 8-bit words, 512 lines).
module tb_sram_array;

  logic [63:0] write_data;
  logic [63:0] read_data;
  logic        read_valid;
  logic [8:0]  write_addr;
  logic [8:0]  read_addr;
  logic [3:0]  write_offset;
  logic        write_enable;
  logic        clk;
  logic        rst_n;

  int checks = 0;
  int errors = 0;

  sram_array dut (
    .writeData   (write_data),
    .readData    (read_data),
    .readValid   (read_valid),
    .writeAddr   (write_addr),
    .readAddr    (read_addr),
    .writeOffset (write_offset),
    .writeEnable (write_enable),
    .clk         (clk),
    .rst_n       (rst_n)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic [8:0] addr, input logic [3:0] offs, input logic [63:0] data);
    write_addr   = addr;
    write_offset = offs;
    write_data   = data;
    write_enable = 1'b1;
  endtask

  task automatic idle_write();
    write_enable = 1'b0;
    write_data   = '0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    write_data   = '0;
    write_addr   = '0;
    read_addr    = 9'd5;
    write_offset = '0;
    write_enable = 1'b0;
    #1;
    check("reset_data", read_data, 64'h0);
    check("reset_valid", {63'h0, read_valid}, 64'h0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("pre_first_edge_valid", {63'h0, read_valid}, 64'h0);
    tick();
    check("first_read_data", read_data, 64'h0);
    check("first_read_valid", {63'h0, read_valid}, 64'h1);

    // full-line write to line 3, read it back
    drive_write(9'd3, 4'b1000, 64'h0123456789ABCDEF);
    read_addr = 9'd3;
    #1;
    check("valid_low_on_addr_change", {63'h0, read_valid}, 64'h0);
    tick();
    check("full_write_data", read_data, 64'h0123456789ABCDEF);
    idle_write();
    #1;
    check("full_write_valid", {63'h0, read_valid}, 64'h1);

    // word write index 2
    drive_write(9'd3, 4'b0010, 64'h0000000000FF0000);
    #1;
    check("valid_low_pending_write", {63'h0, read_valid}, 64'h0);
    tick();
    check("word2_write_first", read_data, 64'h0123456789FFCDEF);
    idle_write();
    tick();
    check("word2_readback", read_data, 64'h0123456789FFCDEF);
    check("word2_valid", {63'h0, read_valid}, 64'h1);

    // word write index 0 with other lanes non-zero: only lane 0 may change
    drive_write(9'd3, 4'b0000, 64'hFFFFFFFFFFFFFF11);
    tick();
    idle_write();
    tick();
    check("word0_masking", read_data, 64'h0123456789FFCD11);

    // same-line read and write in one cycle
    drive_write(9'd7, 4'b1000, 64'h00000000DEADBEEF);
    read_addr = 9'd7;
    tick();
    check("write_first_line7", read_data, 64'h00000000DEADBEEF);
    idle_write();

    // write and read different lines in the same cycle
    drive_write(9'd4, 4'b1000, 64'h4444444444444444);
    read_addr = 9'd3;
    tick();
    check("independent_read", read_data, 64'h0123456789FFCD11);
    idle_write();
    #1;
    check("independent_valid", {63'h0, read_valid}, 64'h1);

    // address change: valid drops at once, returns after one edge
    read_addr = 9'd4;
    #1;
    check("addr_change_valid_low", {63'h0, read_valid}, 64'h0);
    tick();
    check("addr_change_valid_high", {63'h0, read_valid}, 64'h1);
    check("addr_change_data", read_data, 64'h4444444444444444);

    // top word index of line 4
    drive_write(9'd4, 4'b0111, 64'hAA00000000000000);
    tick();
    idle_write();
    tick();
    check("word7_write", read_data, 64'hAA44444444444444);

    // last line of the array
    drive_write(9'd511, 4'b1000, 64'hFEDCBA9876543210);
    tick();
    idle_write();
    read_addr = 9'd511;
    tick();
    check("last_line", read_data, 64'hFEDCBA9876543210);

    // reset mid-stream: outputs clear immediately, contents survive, writes ignored
    drive_write(9'd9, 4'b1000, 64'h9999000011112222);
    tick();
    idle_write();
    read_addr = 9'd9;
    tick();
    check("line9_before_reset", read_data, 64'h9999000011112222);
    rst_n = 1'b0;
    #1;
    check("midreset_data", read_data, 64'h0);
    check("midreset_valid", {63'h0, read_valid}, 64'h0);
    drive_write(9'd9, 4'b1000, 64'hBADBADBADBADBAD0);
    tick();
    idle_write();
    check("reset_holds_data", read_data, 64'h0);
    rst_n = 1'b1;
    #1;
    check("post_release_valid", {63'h0, read_valid}, 64'h0);
    tick();
    check("post_reset_line9", read_data, 64'h9999000011112222);
    check("post_reset_valid", {63'h0, read_valid}, 64'h1);

    // report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
